// File: rtl/stream_pkg.sv
// Shared constants and types for the 4-source round-robin stream mux.
package stream_pkg;

    localparam int unsigned SRC_N = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Last-grant pointer value out of reset, so source 0 wins the first search.
    localparam sel_t PTR_RST = 2'd3;

endpackage

// File: rtl/rr_stream_mux_4_if.sv
// Bundle of the four producer streams and the single consumer stream.
//   d0..d3    : per-source data words
//   in_valid  : per-source valid
//   in_ready  : per-source accept (at most one bit set)
//   out_data  : selected word, registered
//   out_sel   : index of the source that produced out_data
//   out_valid : out_data/out_sel hold a beat
//   out_ready : consumer takes the beat this cycle
// slave is the mux side, master is the producer/consumer side.
interface rr_stream_mux_4_if #(
    parameter int unsigned W = 4
);
    import stream_pkg::*;

    logic [W-1:0]     d0;
    logic [W-1:0]     d1;
    logic [W-1:0]     d2;
    logic [W-1:0]     d3;
    logic [SRC_N-1:0] in_valid;
    logic [SRC_N-1:0] in_ready;
    logic [W-1:0]     out_data;
    sel_t             out_sel;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  d0, d1, d2, d3, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output d0, d1, d2, d3, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_grant_4.sv
// Combinational round-robin grant over four requesters.
//   req          : request vector
//   last         : previously granted index; search starts at last+1
//   en           : gates the one-hot grant (index is still computed)
//   grant_onehot : one-hot grant, zero when en=0 or no request
//   grant_idx    : winning index (0 when no request)
//   any          : at least one request present
module rr_grant_4
    import stream_pkg::*;
(
    input  logic [SRC_N-1:0] req,
    input  sel_t             last,
    input  logic             en,
    output logic [SRC_N-1:0] grant_onehot,
    output sel_t             grant_idx,
    output logic             any
);

    logic found;
    sel_t cand;

    // Scan last+1 .. last+4 (mod 4); the final step lands back on last.
    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= SRC_N; k++) begin
            cand = last + SEL_W'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign any          = |req;
    assign grant_onehot = (en && any) ? (SRC_N'(1) << grant_idx) : '0;

endmodule

// File: rtl/rr_stream_mux_4.sv
// Four valid/ready producers arbitrated round-robin into one registered
// output beat carrying the data word and its source index.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream bundle (slave side), see rr_stream_mux_4_if
module rr_stream_mux_4
    import stream_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_stream_mux_4_if.slave      bus
);

    logic             accept;
    logic             any;
    sel_t             grant_idx;
    logic [SRC_N-1:0] grant_onehot;
    logic [W-1:0]     sel_data;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    sel_t             out_sel_q,   out_sel_d;
    sel_t             last_q,      last_d;

    // Output slot is free, or is being drained this cycle.
    assign accept = ~out_valid_q | bus.out_ready;

    // rst_n in the enable keeps every in_ready low while reset is held.
    rr_grant_4 u_grant (
        .req          (bus.in_valid),
        .last         (last_q),
        .en           (accept & rst_n),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    // Data steering by grant index.
    always_comb begin
        sel_data = bus.d0;
        case (grant_idx)
            2'd0:    sel_data = bus.d0;
            2'd1:    sel_data = bus.d1;
            2'd2:    sel_data = bus.d2;
            default: sel_data = bus.d3;
        endcase
    end

    // Next state: capture on transfer, go empty on idle accept, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (accept) begin
            if (any) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_sel_d   = grant_idx;
                last_d      = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Output register and last-grant pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= PTR_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign bus.in_ready  = grant_onehot;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux_4.sv
// Directed self-checking bench for rr_stream_mux_4.
module tb_rr_stream_mux_4;

    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    rr_stream_mux_4_if #(.W(W)) bus ();

    rr_stream_mux_4 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        chk(tag, 32'(bus.in_ready), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_sel"},   32'(bus.out_sel),   32'(s));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        bus.d0 = a;
        bus.d1 = b;
        bus.d2 = c;
        bus.d3 = d;
    endtask

    logic [3:0] exp_rdy  [4];
    logic [3:0] exp_data [4];

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        exp_rdy[0]  = 4'b0001; exp_rdy[1]  = 4'b0010; exp_rdy[2]  = 4'b0100; exp_rdy[3]  = 4'b1000;
        exp_data[0] = 4'hA;    exp_data[1] = 4'hB;    exp_data[2] = 4'hC;    exp_data[3] = 4'hD;

        // Reset held with all sources requesting: nothing may be accepted.
        rst_n         = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        set_d(4'hA, 4'hB, 4'hC, 4'hD);
        cyc();
        cyc();
        chk_rdy("rst_rdy", 4'b0000);
        chk_out("rst", 1'b0, 2'd0, 4'h0);

        // Idle after reset.
        bus.in_valid = 4'b0000;
        rst_n        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_rdy($sformatf("idle_rdy%0d", i), 4'b0000);
            cyc();
            chk_out($sformatf("idle%0d", i), 1'b0, 2'd0, 4'h0);
        end

        // All four valid, no stall: strict rotation 0,1,2,3,0,...
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_rdy($sformatf("rr_rdy%0d", i), exp_rdy[i % 4]);
            cyc();
            chk_out($sformatf("rr%0d", i), 1'b1, 2'(i % 4), exp_data[i % 4]);
        end
        bus.in_valid = 4'b0000;
        #1;
        chk_rdy("rr_end_rdy", 4'b0000);
        cyc();
        chk("rr_end_valid", 32'(bus.out_valid), 32'd0);

        // Single requester (source 2) granted every cycle.
        set_d(4'h1, 4'h2, 4'h5, 4'h7);
        bus.in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy($sformatf("one_rdy%0d", i), 4'b0100);
            cyc();
            chk_out($sformatf("one%0d", i), 1'b1, 2'd2, 4'h5);
        end

        // Source 0 alone once, leaving the pointer at 0.
        set_d(4'hA, 4'h6, 4'h5, 4'h9);
        bus.in_valid = 4'b0001;
        #1;
        chk_rdy("p0_rdy", 4'b0001);
        cyc();
        chk_out("p0", 1'b1, 2'd0, 4'hA);

        // Sources 1 and 3: capture 1, stall 3 cycles, release grants 3.
        bus.in_valid = 4'b1010;
        #1;
        chk_rdy("s13_rdy", 4'b0010);
        cyc();
        chk_out("s13_cap", 1'b1, 2'd1, 4'h6);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.d1 = 4'h3;
            #1;
            chk_rdy($sformatf("stall_rdy%0d", i), 4'b0000);
            cyc();
            chk_out($sformatf("stall%0d", i), 1'b1, 2'd1, 4'h6);
        end
        bus.out_ready = 1'b1;
        #1;
        chk_rdy("rel_rdy", 4'b1000);
        cyc();
        chk_out("rel", 1'b1, 2'd3, 4'h9);
        bus.in_valid = 4'b0000;
        cyc();
        chk("rel_end_valid", 32'(bus.out_valid), 32'd0);

        // out_ready toggling with all sources valid; pointer is at 3.
        set_d(4'hA, 4'hB, 4'hC, 4'hD);
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = (i % 2 == 0);
            #1;
            chk_rdy($sformatf("tg_rdy%0d", i), (i % 2 == 0) ? exp_rdy[(i / 2) % 4] : 4'b0000);
            cyc();
            chk_out($sformatf("tg%0d", i), 1'b1, 2'((i / 2) % 4), exp_data[(i / 2) % 4]);
        end

        // Reset while a beat is held under stall: out_valid drops at once.
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 2'd0, 4'h0);
        chk_rdy("mid_rst_rdy", 4'b0000);
        cyc();
        rst_n = 1'b1;
        #1;
        chk_rdy("post_rst_rdy", 4'b0001);
        cyc();
        chk_out("post_rst", 1'b1, 2'd0, 4'hA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
